// File: rtl/rv32i_types.sv
// Shared types for the memory-side line bridge: FSM states, line geometry and the byte-lane merge helper.
package rv32i_types;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = 32 - OFFSET_W;
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    MERGE,
    WB,
    RESP
  } bridge_state_t;

  // Byte i of the word is replaced only when its byte enable is set.
  function automatic logic [31:0] mergeWord(input logic [31:0] oldWord,
                                            input logic [31:0] newWord,
                                            input logic [3:0]  be);
    logic [31:0] result;
    result = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) result[8*i +: 8] = newWord[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line buffer (256-bit line, tag, valid): beat fills, byte-enable word merges, word and beat reads.
module line_buffer
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              beatWe_i,
  input  logic [CNT_W-1:0]  beatIdx_i,
  input  logic [BEAT_W-1:0] beatData_i,
  input  logic              mergeEn_i,
  input  logic [2:0]        wordIdx_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  input  logic              tagWe_i,
  input  logic              setValid_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic [31:0]       word_o,
  output logic [BEAT_W-1:0] beat_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o
);

  logic [LINE_W-1:0] line_q;
  logic [TAG_W-1:0]  tag_q;
  logic              valid_q;

  // Fill beats and word merges never coincide; the fill takes priority for safety.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (beatWe_i) begin
        line_q[{beatIdx_i, 6'b0} +: BEAT_W] <= beatData_i;
      end else if (mergeEn_i) begin
        line_q[{wordIdx_i, 5'b0} +: 32] <= mergeWord(line_q[{wordIdx_i, 5'b0} +: 32], wdata_i, be_i);
      end
      if (tagWe_i) tag_q <= tag_i;
      if (setValid_i) valid_q <= 1'b1;
    end
  end

  assign word_o  = line_q[{wordIdx_i, 5'b0} +: 32];
  assign beat_o  = line_q[{beatIdx_i, 6'b0} +: BEAT_W];
  assign tag_o   = tag_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mem_line_bridge.sv
// Serves the CPU single-word memory port from a 4x64-bit burst memory through a write-through line buffer.
// Define MEM_LINE_BRIDGE_BUFFER_EN to allow buffer hits; otherwise every access goes to physical memory.
module mem_line_bridge
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  bridge_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beatWe, mergeEn, tagWe, setValid;
  logic             bufValid, hit, lastBeat;
  logic [TAG_W-1:0] bufTag;
  logic [1:0]       unusedAddrBits;

  assign unusedAddrBits = mem_address[1:0];

`ifdef MEM_LINE_BRIDGE_BUFFER_EN
  assign setValid = tagWe;
`else
  assign setValid = 1'b0;
`endif

  line_buffer u_lineBuffer (
    .clk        (clk),
    .rst        (rst),
    .beatWe_i   (beatWe),
    .beatIdx_i  (cnt_q),
    .beatData_i (pmem_rdata),
    .mergeEn_i  (mergeEn),
    .wordIdx_i  (mem_address[4:2]),
    .wdata_i    (mem_wdata),
    .be_i       (mem_byte_enable),
    .tagWe_i    (tagWe),
    .setValid_i (setValid),
    .tag_i      (mem_address[31:OFFSET_W]),
    .word_o     (mem_rdata),
    .beat_o     (pmem_wdata),
    .tag_o      (bufTag),
    .valid_o    (bufValid)
  );

  assign hit      = bufValid && (bufTag == mem_address[31:OFFSET_W]);
  assign lastBeat = pmem_resp && (cnt_q == CNT_W'(BEATS - 1));

  // A write with no byte lanes completes at once; a simultaneous read and write counts as a write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beatWe  = 1'b0;
    mergeEn = 1'b0;
    tagWe   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          if (mem_byte_enable == 4'b0) begin
            state_d = RESP;
          end else if (hit) begin
            mergeEn = 1'b1;
            cnt_d   = '0;
            state_d = WB;
          end else begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end else if (mem_read) begin
          cnt_d   = '0;
          state_d = hit ? RESP : FILL;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          beatWe = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (lastBeat) begin
            tagWe   = 1'b1;
            state_d = mem_write ? MERGE : RESP;
          end
        end
      end
      MERGE: begin
        mergeEn = 1'b1;
        cnt_d   = '0;
        state_d = WB;
      end
      WB: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (lastBeat) state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_resp   = (state_q == RESP);
  assign pmem_read  = (state_q == FILL);
  assign pmem_write = (state_q == WB);

  always_comb begin
    pmem_address = '0;
    if (state_q == FILL) pmem_address = {mem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
    else if (state_q == WB) pmem_address = {bufTag, {OFFSET_W{1'b0}}};
  end

endmodule

// File: tb/tb_mem_line_bridge.sv
// Self-checking bench for mem_line_bridge: a burst memory responder plus a scoreboard of expected responses.
// Expectations follow MEM_LINE_BRIDGE_BUFFER_EN so the same bench covers both builds.
module tb_mem_line_bridge;

`ifdef MEM_LINE_BRIDGE_BUFFER_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata, pmem_rdata;
  logic        pmem_resp;

  always #5 clk = ~clk;

  mem_line_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  typedef struct {
    bit          isRead;
    logic [31:0] rdata;
    int          fill;
    int          wb;
    int          cycles;
  } expTxn_t;

  expTxn_t     sbQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] pmemArr [int unsigned];
  logic [63:0] refArr  [int unsigned];
  bit          refValid = 1'b0;
  logic [26:0] refTag = '0;
  logic [31:0] expAddr = '0;
  int          gap = 0;
  int          fillCnt = 0;
  int          wbCnt = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Physical memory: serves one beat per (gap+1) cycles while a strobe is up, capturing write-back beats.
  initial begin
    int          beatIdx;
    int          gapCnt;
    int unsigned key;
    beatIdx    = 0;
    gapCnt     = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (!rst || !(pmem_read || pmem_write)) begin
        beatIdx = 0;
        gapCnt  = 0;
      end else if (gapCnt < gap) begin
        gapCnt++;
      end else begin
        key = pmem_address + 32'(beatIdx) * 32'd8;
        checkOutput("pmemAddr", {32'b0, pmem_address}, {32'b0, expAddr});
        if (pmem_read) begin
          pmem_rdata = pmemArr.exists(key) ? pmemArr[key] : 64'h0;
          fillCnt++;
        end else begin
          checkOutput("wbBeat", pmem_wdata, refArr.exists(key) ? refArr[key] : 64'h0);
          pmemArr[key] = pmem_wdata;
          wbCnt++;
        end
        pmem_resp = 1'b1;
        gapCnt    = 0;
        beatIdx++;
      end
    end
  end

  // Models the request, queues its expected outcome, then pops and checks it when mem_resp arrives.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata, input int g);
    expTxn_t     e;
    expTxn_t     got;
    int unsigned key;
    logic [63:0] beat;
    logic [31:0] word;
    bit          hit;
    int          cycles;
    int          beatCycles;
    key    = {addr[31:3], 3'b000};
    beat   = refArr.exists(key) ? refArr[key] : 64'h0;
    word   = addr[2] ? beat[63:32] : beat[31:0];
    hit    = refValid && (refTag == addr[31:5]);
    e.isRead = !wr;
    e.rdata  = word;
    if (wr && be == 4'b0) begin
      e.fill = 0;
      e.wb   = 0;
    end else begin
      e.fill = hit ? 0 : 4;
      e.wb   = wr ? 4 : 0;
    end
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
      if (addr[2]) beat[63:32] = word;
      else beat[31:0] = word;
      refArr[key] = beat;
    end
    if (e.fill != 0) begin
      refTag   = addr[31:5];
      refValid = BufEn;
    end
    beatCycles = 4 * (g + 1);
    e.cycles = 1 + ((e.fill != 0) ? beatCycles : 0) + ((e.fill != 0 && e.wb != 0) ? 1 : 0)
                 + ((e.wb != 0) ? beatCycles : 0);
    sbQ.push_back(e);

    @(negedge clk);
    gap             = g;
    fillCnt         = 0;
    wbCnt           = 0;
    expAddr         = {addr[31:5], 5'b0};
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wdata;
    cycles          = 0;
    while (!mem_resp && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    got = sbQ.pop_front();
    if (!mem_resp) begin
      checkOutput("respTimeout", 64'd0, 64'd1);
    end else begin
      checkOutput("latency", 64'(cycles), 64'(got.cycles));
      checkOutput("fillBeats", 64'(fillCnt), 64'(got.fill));
      checkOutput("wbBeats", 64'(wbCnt), 64'(got.wb));
      if (got.isRead) checkOutput("rdata", {32'b0, mem_rdata}, {32'b0, got.rdata});
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    checkOutput("respPulse", {63'b0, mem_resp}, 64'd0);
    checkOutput("strobesIdle", {62'b0, pmem_read, pmem_write}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    pmemArr[32'h40] = 64'hAAAA_BBBB_CCCC_DDDD;
    pmemArr[32'h48] = 64'h1111_2222_3333_4444;
    pmemArr[32'h50] = 64'h5555_6666_7777_8888;
    pmemArr[32'h58] = 64'h1234_5678_9ABC_DEF0;
    pmemArr[32'h1000] = 64'h0102_0304_0506_0708;
    pmemArr[32'h1008] = 64'h1112_1314_1516_1718;
    pmemArr[32'h1010] = 64'h2122_2324_2526_2728;
    pmemArr[32'h1018] = 64'h3132_3334_3536_3738;
    pmemArr[32'h2000] = 64'hF0F1_F2F3_F4F5_F6F7;
    pmemArr[32'h2008] = 64'hE0E1_E2E3_E4E5_E6E7;
    pmemArr[32'h2010] = 64'hD0D1_D2D3_D4D5_D6D7;
    pmemArr[32'h2018] = 64'hC0C1_C2C3_C4C5_C6C7;
    foreach (pmemArr[k]) refArr[k] = pmemArr[k];

    rst             = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'hF;
    mem_address     = 32'h0000_0044;
    mem_wdata       = 32'hFFFF_FFFF;
    #3;
    checkOutput("rstResp", {63'b0, mem_resp}, 64'd0);
    checkOutput("rstPmemRead", {63'b0, pmem_read}, 64'd0);
    checkOutput("rstPmemWrite", {63'b0, pmem_write}, 64'd0);
    checkOutput("rstPmemAddr", {32'b0, pmem_address}, 64'd0);
    checkOutput("rstPmemWdata", pmem_wdata, 64'd0);
    checkOutput("rstRdata", {32'b0, mem_rdata}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0058, 4'hF, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 4'b0100, 32'h00EE_0000, 0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 2);
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_1004, 4'b1000, 32'h7700_0000, 1);
    applyStimulus(1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_1008, 4'b0000, 32'hCAFE_F00D, 0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0048, 4'b0011, 32'h0000_5A5A, 0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0048, 4'hF, 32'h0, 0);

    // Reset mid-fill: strobe must drop asynchronously and the buffer must come back empty.
    @(negedge clk);
    gap         = 2;
    fillCnt     = 0;
    expAddr     = 32'h0000_2000;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    mem_address = 32'h0000_2008;
    cycles      = 0;
    while (fillCnt < 2 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("midFillBeats", 64'(fillCnt), 64'd2);
    checkOutput("midFillRead", {63'b0, pmem_read}, 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncRstRead", {63'b0, pmem_read}, 64'd0);
    checkOutput("asyncRstAddr", {32'b0, pmem_address}, 64'd0);
    mem_read = 1'b0;
    refValid = 1'b0;
    refTag   = '0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_2008, 4'hF, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 32'h0000_201C, 4'hF, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_line_bridge.md
# mem_line_bridge

Memory-side neighbour of the multicycle datapath and its control unit. It takes the CPU's single-word memory port (`mem_address`, `mem_rdata`, `mem_wdata`, byte enables, read/write strobes, `mem_resp`) and serves it from a burst-only physical memory that moves 256-bit lines as four 64-bit beats. A one-line buffer turns repeated accesses to the same line into one-cycle hits. Sub-word stores are done by read-modify-write, because the physical memory has no byte enables.

## Interface
- `BEATS`, 4: beats per line. Fixed; the line is 32 bytes.
- `BEAT_W`, 64: width of one beat in bits.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `mem_read` in 1: CPU read request. Held until `mem_resp`.
- `mem_write` in 1: CPU write request. Held until `mem_resp`.
- `mem_byte_enable` in 4: byte lanes to write, aligned to `mem_address[1:0]=0`.
- `mem_address` in 32: word address; bits [1:0] are ignored.
- `mem_wdata` in 32: store data, already lane-shifted.
- `mem_rdata` out 32: the addressed word of the line buffer.
- `mem_resp` out 1: one-cycle completion pulse.
- `pmem_read` out 1: line fill request.
- `pmem_write` out 1: line write-back request.
- `pmem_address` out 32: line-aligned address `{tag, 5'b0}`.
- `pmem_wdata` out 64: current write-back beat.
- `pmem_rdata` in 64: current fill beat.
- `pmem_resp` in 1: one beat transferred this cycle. Beats may have gaps between them.

## Operation
- Line buffer: 256-bit `line`, 27-bit `tag`, `valid` bit.
  - Hit means `valid && tag == mem_address[31:5]`.
  - Beat k holds line bytes 8k..8k+7. Beat 0 transfers first.
- `mem_rdata = line[mem_address[4:2]*32 +: 32]`. Combinational. Only meaningful while `mem_resp`=1.
- States:
  - IDLE → RESP: read hit, or write with `mem_byte_enable==0`.
  - IDLE → WB: write hit. The write is merged into `line` on the transition.
  - IDLE → FILL: read miss or write miss. The beat counter is cleared.
  - FILL: hold `pmem_read`=1. On each `pmem_resp`, store `pmem_rdata` into beat `cnt` and increment `cnt`.
    - Last beat, read request: set `valid`, load `tag`, go to RESP.
    - Last beat, write request: set `valid`, load `tag`, go to MERGE.
  - MERGE: merge the write into `line`, clear `cnt`, go to WB. Takes one cycle.
  - WB: hold `pmem_write`=1 with `pmem_wdata = beat cnt`. Increment `cnt` on each `pmem_resp`. After the last beat, go to RESP.
  - RESP: assert `mem_resp`=1 for exactly one cycle, then go to IDLE.
- Merge rule: byte i of the addressed word takes `mem_wdata[8i+7:8i]` when `mem_byte_enable[i]`. Other bytes are unchanged.
- Writes are write-through. The buffer stays valid and keeps the merged data.
- If `mem_read` and `mem_write` are both high, the request is treated as a write.
- `pmem_resp` in IDLE, MERGE or RESP is ignored.
- `cnt` is 2 bits. It wraps 3→0 on the last beat; the wrap is the completion condition.
- `pmem_address` comes from the request address in FILL and from `tag` in WB. It is `{mem_address[31:5],5'b0}` in both cases.

## Timing
- All state changes happen on the rising edge of `clk`.
- Values during reset (`rst`=0, asynchronous):
  - state IDLE, `valid`=0, `line`=0, `tag`=0, `cnt`=0.
  - So `mem_resp`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `mem_rdata`=0.
- Latencies for a request first seen in cycle N:
  - Hit or empty write: `mem_resp` in N+1.
  - Read miss: `mem_resp` one cycle after the 4th fill `pmem_resp`.
  - Write hit: `mem_resp` one cycle after the 4th write-back `pmem_resp`.
  - Write miss: fill, then MERGE for one cycle, then write-back, then RESP.
- The CPU must hold the request stable until `mem_resp`. A request visible in the RESP cycle is not accepted; it is evaluated in the following IDLE cycle.
- Reset in the middle of a fill or write-back drops `pmem_read`/`pmem_write` immediately and invalidates the buffer. The next access misses.

## Configuration
- `MEM_LINE_BRIDGE_BUFFER_EN` defined: behaviour as described above.
- Undefined: `valid` is never set, so every access goes to physical memory.
  - A read costs 4 beats.
  - A write costs 8 beats (fill, then write-back).
  - A write with byte enables 0 still completes in N+1.

## Structure
- Shared package (`rv32i_types`):
  - `bridge_state_t` enum {IDLE, FILL, MERGE, WB, RESP}.
  - `LINE_W`=256 and `OFFSET_W`=5.
- One sub-module, `line_buffer`: holds `line`/`tag`/`valid` and provides beat write, byte-enable word merge, word read and beat read. It resets asynchronously on `rst`.

## Test plan
- Read miss at 0x0000_0044. Return beat0=0xAAAA_BBBB_CCCC_DDDD, then 3 more beats.
  - Expect `pmem_read` at 0x0000_0040 for the fill.
  - Expect one `mem_resp` with `mem_rdata`=0xAAAA_BBBB.
- Read 0x0000_0058 next, with beat3=0x1234_5678_9ABC_DEF0.
  - Expect `mem_resp` in N+1, no `pmem_read`, `mem_rdata`=0x9ABC_DEF0.
- Write to 0x0000_0040 with BE=4'b0100, wdata=0x00EE_0000 (a hit).
  - Expect 4 `pmem_write` beats at 0x0000_0040, with beat0=0xAAAA_BBBB_CCEE_DDDD.
  - Expect `mem_resp` after the 4th `pmem_resp`.
- Write miss to 0x0000_1000 with BE=4'b1111, and 2-cycle gaps between `pmem_resp` beats.
  - Expect 4 fill beats, 1 MERGE cycle, 4 write-back beats, then `mem_resp`.
- Assert `rst`=0 after the 2nd fill beat.
  - Expect `pmem_read` to fall with no clock edge.
  - A re-read of the same line misses again.
- Write with BE=4'b0000.
  - Expect `mem_resp` in N+1 and no `pmem_read`/`pmem_write`.
  - Repeat with the macro undefined: reads and writes show 4 and 8 beats respectively.
